slave_mem: RTL and testbench
============================

SLAVE_MEM -- requirements
Module: slave_mem

Interface
REQ-001 SHALL have parameter: SLAVE_ADDR, 7'b1010101, 7-bit I2C address this responder answers to.
REQ-002 SHALL have parameter: MEM_DEPTH, 16, number of 8-bit memory locations; pointer width is log2(MEM_DEPTH).
REQ-003 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: scl  input  1  I2C clock from master, never driven by this block.
REQ-006 SHALL have port: sda  inout  1  I2C data, open-drain: drive 0 or release to 'z', never drive 1.
REQ-007 SHALL have port: busy  output  1  high from address-matched START until STOP or repeated START.
REQ-008 SHALL have port: done  output  1  one-clk pulse on STOP ending an address-matched transaction.
REQ-009 SHALL have port: rxData  output  8  last data byte written to memory.
REQ-010 SHALL have port: rxValid  output  1  one-clk pulse when rxData updates.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers and detect edges on synchronized values only.
REQ-012 SHALL detect START as sda falling with scl high, STOP as sda rising with scl high, in any state.
REQ-013 SHALL sample sda on scl rising edge; SHALL change its own sda drive only after scl falling edge.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
REQ-015 IDLE -> ADDR on START; ADDR shifts 8 bits MSB first (7 addr + rw).
REQ-016 On address match SHALL go to ADDR_ACK and drive sda low for the 9th bit; on mismatch SHALL release sda and go to WAIT_STOP.
REQ-017 After ADDR_ACK with rw=0 -> PTR: received byte loads pointer (pointer = byte mod MEM_DEPTH), ACK in PTR_ACK, then WDATA.
REQ-018 WDATA: each received byte written to mem[pointer], rxData/rxValid updated at 8th-bit sample, ACK in WDATA_ACK, repeat.
REQ-019 After ADDR_ACK with rw=1 -> RDATA: drive mem[pointer] MSB first, MSB put on sda after scl falling edge ending ACK bit.
REQ-020 RACK: release sda, sample master ACK; ACK (0) -> next byte in RDATA, NACK (1) -> WAIT_STOP with sda released.
REQ-021 Repeated START in any state SHALL abort the byte in progress (no memory write), keep pointer, go to ADDR.
REQ-022 STOP in any state SHALL release sda, go to IDLE, pulse done if busy was high, clear busy.
REQ-023 Pointer SHALL wrap from MEM_DEPTH-1 to 0.
REQ-024 ACK low SHALL be released on the scl falling edge ending the 9th bit.

Reset
REQ-025 rst low SHALL immediately force IDLE, sda released, busy=0, done=0, rxValid=0, rxData=8'h00, pointer=0.
REQ-026 Memory contents SHALL be cleared to 8'h00 on reset.
REQ-027 Reset mid-transaction SHALL discard the partial byte; block resumes only on the next START after rst high.

Configuration
REQ-028 Macro PTR_AUTOINC_EN defined: pointer increments after each written byte ACK and after each read byte is sent.
REQ-029 PTR_AUTOINC_EN undefined: pointer changes only via PTR byte; successive reads/writes hit the same location.

Verification
REQ-030 Write: START, 0xAA (0x55+W), ptr 0x03, data 0x2F, STOP -> three ACKs, mem[3]=0x2F, rxData=0x2F, rxValid once, done once.
REQ-031 Read: after REQ-030, write ptr 0x03, repeated START, 0xAB, master NACK, STOP -> sda bits 0x2F, done once.
REQ-032 Address mismatch: START, 0xA8, 8 bits, STOP -> sda stays 'z' throughout, busy=0, done=0.
REQ-033 Wrap (PTR_AUTOINC_EN): ptr 0x0F, data 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22.
REQ-034 Reset mid-write: rst low after 4 data bits of byte 0x2F -> sda 'z', busy=0, mem[3] stays 0x00; next full write ACKed.
REQ-035 Multi-byte read, master ACK twice then NACK -> three consecutive locations returned, sda released after NACK.

Source files
------------

// File: rtl/slave_mem.sv
// I2C responder fronting a small byte memory with a loadable pointer.
// Define PTR_AUTOINC_EN to advance the pointer after every written or read byte.
module slave_mem #(
    parameter logic [6:0]  SLAVE_ADDR = 7'b1010101,
    parameter int unsigned MEM_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       done,
    output logic [7:0] rxData,
    output logic       rxValid
);
    localparam int unsigned PW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RACK      = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    // [1] is the synchronized value, [2] its previous sample for edge detection
    logic [2:0] scl_sync, sda_sync;
    logic       scl_s, scl_p, sda_s, sda_p;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, tx_q, tx_d, rx_data_q, rx_data_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic          rx_valid_q, rx_valid_d, rw_q, rw_d, nack_q, nack_d;
    logic          mem_we;
    logic [7:0]    rx_next;
    logic [7:0]    mem [MEM_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl};
            sda_sync <= {sda_sync[1:0], sda};
        end
    end

    assign scl_s     = scl_sync[1];
    assign scl_p     = scl_sync[2];
    assign sda_s     = sda_sync[1];
    assign sda_p     = sda_sync[2];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
    assign rx_next   = {shift_q[6:0], sda_s};

`ifdef PTR_AUTOINC_EN
    assign ptr_inc = (ptr_q == PW'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
`else
    assign ptr_inc = ptr_q;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rx_data_d  = rx_data_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        rw_d       = rw_q;
        nack_d     = nack_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_ADDR, S_PTR, S_WDATA: begin
                if (scl_rise) begin
                    shift_d   = rx_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == S_ADDR) begin
                            rw_d = sda_s;
                            if (rx_next[7:1] == SLAVE_ADDR) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end else if (state_q == S_PTR) begin
                            ptr_d   = PW'(32'(rx_next) % MEM_DEPTH);
                            state_d = S_PTR_ACK;
                        end else begin
                            mem_we     = 1'b1;
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            state_d    = S_WDATA_ACK;
                        end
                    end
                end
            end
            // First falling edge starts the ACK low, the next one ends it
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d      = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            tx_d    = mem[ptr_q];
                            oe_d    = ~mem[ptr_q][7];
                            state_d = S_RDATA;
                        end else if (state_q == S_ADDR_ACK) begin
                            state_d = S_PTR;
                        end else if (state_q == S_PTR_ACK) begin
                            state_d = S_WDATA;
                        end else begin
                            ptr_d   = ptr_inc;
                            state_d = S_WDATA;
                        end
                    end
                end
            end
            S_RDATA: begin
                if (scl_fall) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        oe_d    = 1'b0;
                        ptr_d   = ptr_inc;
                        state_d = S_RACK;
                    end else begin
                        oe_d = ~tx_q[6];
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            S_RACK: begin
                if (scl_rise) begin
                    nack_d = sda_s;
                end else if (scl_fall) begin
                    if (!nack_q) begin
                        tx_d      = mem[ptr_q];
                        oe_d      = ~mem[ptr_q][7];
                        bit_cnt_d = 3'd0;
                        state_d   = S_RDATA;
                    end else begin
                        state_d = S_WAIT_STOP;
                    end
                end
            end
            S_WAIT_STOP: ;
            default: state_d = S_IDLE;
        endcase

        // Bus conditions override whatever the byte engine decided
        if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            done_d  = busy_q;
            busy_d  = 1'b0;
            mem_we  = 1'b0;
        end else if (start_det) begin
            state_d    = S_ADDR;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = 3'd0;
            mem_we     = 1'b0;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
            ptr_d      = ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            rx_data_q  <= 8'h00;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rx_data_q  <= rx_data_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: 8'h00};
        end else if (mem_we) begin
            mem[ptr_q] <= rx_next;
        end
    end

    assign sda     = oe_q ? 1'b0 : 1'bz;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rxData  = rx_data_q;
    assign rxValid = rx_valid_q;

endmodule

// File: tb/tb_slave_mem.sv
// Randomized bench for slave_mem: an I2C master model against a memory/pointer reference model.
module tb_slave_mem;
    localparam int Q = 6;
`ifdef PTR_AUTOINC_EN
    localparam bit AutoInc = 1'b1;
`else
    localparam bit AutoInc = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scl_m = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;
    logic busy, done, rx_valid;
    logic [7:0] rx_data;

    int n_checks = 0, n_fail = 0;
    int done_cnt = 0, rxv_cnt = 0, z_viol = 0, busy_seen = 0;
    bit mon_en = 1'b0;
    logic [7:0] mem_model [16];
    logic [7:0] wbuf [8];
    int ptr_model = 0;

    always #5 clk = ~clk;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    slave_mem dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl_m),
        .sda     (sda),
        .busy    (busy),
        .done    (done),
        .rxData  (rx_data),
        .rxValid (rx_valid)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rx_valid) rxv_cnt++;
        if (mon_en && busy) busy_seen++;
    end

    always @(posedge clk) begin
        if (mon_en && !sda_low && sda !== 1'b1) z_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic bv, output logic seen);
        sda_low = ~bv;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        seen = sda;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_low = 1'b1;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    // ack = 1 when the responder pulled the 9th bit low
    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic [7:0] sh;
        logic s;
        sh = b;
        for (int i = 0; i < 8; i++) begin
            send_bit(sh[7], s);
            sh = {sh[6:0], 1'b0};
        end
        send_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic master_ack);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            b = {b[6:0], s};
        end
        send_bit(~master_ack, s);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_model[i[3:0]] = 8'h00;
        ptr_model = 0;
    endtask

    task automatic txn_write(input logic [7:0] p, input int n);
        logic ack;
        int d0, v0;
        d0 = done_cnt;
        v0 = rxv_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        check("wr_addr_ack", 32'(ack), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        write_byte(p, ack);
        check("wr_ptr_ack", 32'(ack), 32'd1);
        ptr_model = int'(p) % 16;
        for (int i = 0; i < n; i++) begin
            write_byte(wbuf[i[2:0]], ack);
            check("wr_data_ack", 32'(ack), 32'd1);
            check("wr_rxdata", 32'(rx_data), 32'(wbuf[i[2:0]]));
            mem_model[ptr_model[3:0]] = wbuf[i[2:0]];
            if (AutoInc) ptr_model = (ptr_model + 1) % 16;
        end
        i2c_stop();
        check("wr_rxvalid_cnt", 32'(rxv_cnt - v0), 32'(n));
        check("wr_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("wr_busy_end", 32'(busy), 32'd0);
    endtask

    task automatic txn_read(input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] b;
        int d0;
        d0 = done_cnt;
        i2c_start();
        write_byte(8'hAA, ack);
        check("rd_addr_w_ack", 32'(ack), 32'd1);
        write_byte(p, ack);
        check("rd_ptr_ack", 32'(ack), 32'd1);
        ptr_model = int'(p) % 16;
        i2c_start();
        write_byte(8'hAB, ack);
        check("rd_addr_r_ack", 32'(ack), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(b, i != n - 1);
            check("rd_data", 32'(b), 32'(mem_model[ptr_model[3:0]]));
            if (AutoInc) ptr_model = (ptr_model + 1) % 16;
        end
        wait_clk(Q);
        check("rd_sda_released", 32'(sda), 32'd1);
        i2c_stop();
        check("rd_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("rd_busy_end", 32'(busy), 32'd0);
    endtask

    task automatic txn_mismatch(input logic [7:0] addr_byte);
        logic ack;
        int d0, z0, b0;
        d0 = done_cnt;
        z0 = z_viol;
        b0 = busy_seen;
        mon_en = 1'b1;
        i2c_start();
        write_byte(addr_byte, ack);
        check("mm_addr_nack", 32'(ack), 32'd0);
        write_byte(8'($urandom), ack);
        check("mm_data_nack", 32'(ack), 32'd0);
        i2c_stop();
        mon_en = 1'b0;
        check("mm_sda_z", 32'(z_viol - z0), 32'd0);
        check("mm_busy", 32'(busy_seen - b0), 32'd0);
        check("mm_done", 32'(done_cnt - d0), 32'd0);
    endtask

    initial begin
        logic ack;
        logic s;
        logic [6:0] a;
        int kind, n;
        logic [7:0] p;

        model_reset();
        wait_clk(5);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rxvalid", 32'(rx_valid), 32'd0);
        check("rst_rxdata", 32'(rx_data), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        rst = 1'b1;
        wait_clk(5);

        wbuf[0] = 8'h2F;
        txn_write(8'h03, 1);
        txn_read(8'h03, 1);
        txn_mismatch(8'hA8);

        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        txn_write(8'h0F, 2);
        txn_read(8'h0F, 2);

        // Reset in the middle of a data byte
        i2c_start();
        write_byte(8'hAA, ack);
        write_byte(8'h03, ack);
        send_bit(1'b0, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        send_bit(1'b0, s);
        rst = 1'b0;
        sda_low = 1'b0;
        wait_clk(4);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sda", 32'(sda), 32'd1);
        check("midrst_rxvalid", 32'(rx_valid), 32'd0);
        scl_m = 1'b1;
        wait_clk(Q);
        rst = 1'b1;
        model_reset();
        wait_clk(Q);
        txn_read(8'h03, 1);
        wbuf[0] = 8'h2F;
        txn_write(8'h03, 1);
        txn_read(8'h03, 1);

        wbuf[0] = 8'hC1;
        wbuf[1] = 8'h5E;
        wbuf[2] = 8'h97;
        txn_write(8'h04, 3);
        txn_read(8'h04, 3);

        for (int t = 0; t < 20; t++) begin
            kind = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 4));
            p = 8'($urandom);
            if (kind <= 1) begin
                for (int i = 0; i < 8; i++) wbuf[i[2:0]] = 8'($urandom);
                txn_write(p, n);
            end else if (kind == 2) begin
                txn_read(p, n);
            end else begin
                a = 7'($urandom);
                if (a == 7'h55) a = 7'h54;
                txn_mismatch({a, 1'($urandom)});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
